// File: rtl/packer_pkg.sv
// Shared types and constants for the sample packer: lane/frame types and the
// pad helper used when a short frame is closed early.
package packer_pkg;
  localparam int DATA_W = 4;
  localparam int LANES  = 4;
  localparam int CNT_W  = $clog2(LANES + 1);

  typedef logic [DATA_W-1:0] lane_t;
  typedef lane_t [LANES-1:0] frame_t;

  localparam lane_t PAD = lane_t'(0);

  // Replace every lane above last_idx with PAD.
  function automatic frame_t pad_frame(input frame_t f, input logic [CNT_W-1:0] last_idx);
    frame_t r;
    for (int i = 0; i < LANES; i++) begin
      r[i] = (i > int'(last_idx)) ? PAD : f[i];
    end
    return r;
  endfunction
endpackage

// File: rtl/frame_out_reg.sv
// Output holding register for packed frames: loads a new frame when free and
// holds data/count stable while the consumer stalls.
module frame_out_reg
  import packer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  frame_t           frame_in,
  input  logic [CNT_W-1:0] count_in,
  input  logic             out_ready,
  output logic             out_valid,
  output frame_t           data_out,
  output logic [CNT_W-1:0] out_count,
  output logic             out_free
);
  logic             valid_q, valid_d;
  frame_t           data_q, data_d;
  logic [CNT_W-1:0] count_q, count_d;

  assign out_free  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign data_out  = data_q;
  assign out_count = count_q;

  // Caller only asserts load when out_free, so a pending frame is never overwritten.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    count_d = count_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = frame_in;
      count_d = count_in;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/sample_packer.sv
// Serial-to-parallel packer: gathers samples into a LANES-wide frame (lane 0
// oldest), supports early close via in_last, and backs up one frame when stalled.
module sample_packer
  import packer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  lane_t            in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output frame_t           data_out,
  output logic [CNT_W-1:0] out_count
);
  frame_t           fill_buf_q, fill_buf_d;
  logic [CNT_W-1:0] fill_cnt_q, fill_cnt_d;
  logic             pending_q, pending_d;

  logic   accept, complete, out_free, load;
  frame_t merged, load_src;

  assign in_ready = !pending_q && !rst;
  assign accept   = in_valid && in_ready;
  assign complete = accept && ((fill_cnt_q == CNT_W'(LANES - 1)) || in_last);
  assign load     = (complete || pending_q) && out_free;
  assign load_src = accept ? merged : fill_buf_q;

  always_comb begin
    merged = fill_buf_q;
    for (int i = 0; i < LANES; i++) begin
      if (fill_cnt_q == CNT_W'(i)) merged[i] = in_data;
    end
  end

  // While pending, fill_cnt keeps the index of the last real lane so the
  // frame length survives until the output register frees up.
  always_comb begin
    fill_buf_d = fill_buf_q;
    fill_cnt_d = fill_cnt_q;
    pending_d  = pending_q;
    if (accept) begin
      fill_buf_d = merged;
      if (!complete)     fill_cnt_d = fill_cnt_q + CNT_W'(1);
      else if (out_free) fill_cnt_d = '0;
      else               pending_d  = 1'b1;
    end else if (pending_q && out_free) begin
      pending_d  = 1'b0;
      fill_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_cnt_q <= '0;
      pending_q  <= 1'b0;
    end else begin
      fill_cnt_q <= fill_cnt_d;
      pending_q  <= pending_d;
    end
    fill_buf_q <= fill_buf_d;
  end

  frame_out_reg u_out (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .frame_in  (pad_frame(load_src, fill_cnt_q)),
    .count_in  (fill_cnt_q + CNT_W'(1)),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .data_out  (data_out),
    .out_count (out_count),
    .out_free  (out_free)
  );
endmodule
